// File: rtl/cnt_pkg.sv
// Shared types for the LED window counter: count modes and bounce direction.
package cnt_pkg;

  typedef enum logic [1:0] {
    UP     = 2'd0,
    DOWN   = 2'd1,
    BOUNCE = 2'd2,
    HOLD   = 2'd3
  } count_mode_t;

  typedef enum logic {
    UP_DIR   = 1'b0,
    DOWN_DIR = 1'b1
  } dir_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles; clear restarts the count.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_p0 <= '0;
    end else if (clear) begin
      ps_p0 <= '0;
    end else if (enable) begin
      ps_p0 <= (ps_p0 == PS_LAST) ? '0 : ps_p0 + 1'b1;
    end
  end

  assign tick = enable && (ps_p0 == PS_LAST);

endmodule

// File: rtl/cnt_window.sv
// Loadable up/down/bounce/hold counter with prescaler, wrap/saturate policy
// and a registered LED window selecting one LED_W-wide slice of the count.
module cnt_window
  import cnt_pkg::*;
#(
  parameter int N        = 16,
  parameter int LED_W    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0,
  localparam int NWIN    = N / LED_W,
  localparam int WS_W    = (NWIN > 1) ? $clog2(NWIN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load,
  input  logic [N-1:0]     load_val,
  input  logic [WS_W-1:0]  win_sel,
  output logic [N-1:0]     count,
  output logic [LED_W-1:0] led_bus,
  output logic             wrap
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  logic             tick;
  logic [N-1:0]     cnt_p0, cnt_nxt, cnt_inc, cnt_dec;
  dir_t             dir_p0, dir_nxt;
  logic             wrap_p0, wrap_nxt;
  logic [LED_W-1:0] led_p1, led_nxt;
  count_mode_t      mode_e;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (clear | load),
    .tick   (tick)
  );

  assign mode_e  = count_mode_t'(mode);
  assign cnt_inc = cnt_p0 + CNT_ONE;
  assign cnt_dec = cnt_p0 - CNT_ONE;

  always_comb begin
    cnt_nxt  = cnt_p0;
    dir_nxt  = dir_p0;
    wrap_nxt = 1'b0;
    if (clear) begin
      cnt_nxt = '0;
      dir_nxt = UP_DIR;
    end else if (load) begin
      cnt_nxt = load_val;
    end else if (tick) begin
      case (mode_e)
        UP: begin
          if (SATURATE != 0) begin
            if (cnt_p0 != CNT_MAX) begin
              cnt_nxt  = cnt_inc;
              wrap_nxt = (cnt_inc == CNT_MAX);
            end
          end else begin
            cnt_nxt  = cnt_inc;
            wrap_nxt = (cnt_p0 == CNT_MAX);
          end
        end
        DOWN: begin
          if (SATURATE != 0) begin
            if (cnt_p0 != '0) begin
              cnt_nxt  = cnt_dec;
              wrap_nxt = (cnt_dec == '0);
            end
          end else begin
            cnt_nxt  = cnt_dec;
            wrap_nxt = (cnt_p0 == '0);
          end
        end
        BOUNCE: begin
          // A load can park the count on an endpoint still heading outward;
          // step back inward rather than wrapping around.
          if ((dir_p0 == UP_DIR && cnt_p0 != CNT_MAX) || (dir_p0 == DOWN_DIR && cnt_p0 == '0)) begin
            cnt_nxt  = cnt_inc;
            wrap_nxt = (cnt_inc == CNT_MAX);
            dir_nxt  = (cnt_inc == CNT_MAX) ? DOWN_DIR : UP_DIR;
          end else begin
            cnt_nxt  = cnt_dec;
            wrap_nxt = (cnt_dec == '0);
            dir_nxt  = (cnt_dec == '0) ? UP_DIR : DOWN_DIR;
          end
        end
        HOLD: begin
          cnt_nxt = cnt_p0;
        end
      endcase
    end
  end

  always_comb begin
    led_nxt = cnt_p0[LED_W-1:0];
    for (int w = 0; w < NWIN; w++) begin
      if ({1'b0, win_sel} == (WS_W + 1)'(w)) begin
        led_nxt = cnt_p0[w*LED_W +: LED_W];
      end
    end
  end

  // Stage p0: counter state; stage p1: LED window register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0  <= '0;
      dir_p0  <= UP_DIR;
      wrap_p0 <= 1'b0;
      led_p1  <= '0;
    end else begin
      cnt_p0  <= cnt_nxt;
      dir_p0  <= dir_nxt;
      wrap_p0 <= wrap_nxt;
      led_p1  <= led_nxt;
    end
  end

  assign count   = cnt_p0;
  assign wrap    = wrap_p0;
  assign led_bus = led_p1;

endmodule

// File: tb/tb_cnt_window.sv
// Directed bench for cnt_window across four parameter sets sharing one clock.
module tb_cnt_window;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // a: N=16, PRESCALE=1, wrapping
  logic a_en, a_clear, a_load, a_win, a_wrap;
  logic [1:0] a_mode;
  logic [15:0] a_lv, a_count;
  logic [7:0] a_led;
  // p: N=16, PRESCALE=4
  logic p_en, p_clear, p_load, p_win, p_wrap;
  logic [1:0] p_mode;
  logic [15:0] p_lv, p_count;
  logic [7:0] p_led;
  // b: N=4, LED_W=4, bounce
  logic b_en, b_clear, b_load, b_win, b_wrap;
  logic [1:0] b_mode;
  logic [3:0] b_lv, b_count, b_led;
  // s: N=16, SATURATE=1
  logic s_en, s_clear, s_load, s_win, s_wrap;
  logic [1:0] s_mode;
  logic [15:0] s_lv, s_count;
  logic [7:0] s_led;

  cnt_window #(.N(16), .LED_W(8), .PRESCALE(1), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst_n), .enable(a_en), .mode(a_mode), .clear(a_clear), .load(a_load),
    .load_val(a_lv), .win_sel(a_win), .count(a_count), .led_bus(a_led), .wrap(a_wrap));
  cnt_window #(.N(16), .LED_W(8), .PRESCALE(4), .SATURATE(0)) u_p (
    .clk(clk), .rst(rst_n), .enable(p_en), .mode(p_mode), .clear(p_clear), .load(p_load),
    .load_val(p_lv), .win_sel(p_win), .count(p_count), .led_bus(p_led), .wrap(p_wrap));
  cnt_window #(.N(4), .LED_W(4), .PRESCALE(1), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst_n), .enable(b_en), .mode(b_mode), .clear(b_clear), .load(b_load),
    .load_val(b_lv), .win_sel(b_win), .count(b_count), .led_bus(b_led), .wrap(b_wrap));
  cnt_window #(.N(16), .LED_W(8), .PRESCALE(1), .SATURATE(1)) u_s (
    .clk(clk), .rst(rst_n), .enable(s_en), .mode(s_mode), .clear(s_clear), .load(s_load),
    .load_val(s_lv), .win_sel(s_win), .count(s_count), .led_bus(s_led), .wrap(s_wrap));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {a_en, a_clear, a_load, a_win} = '0; a_mode = 2'd0; a_lv = '0;
    {p_en, p_clear, p_load, p_win} = '0; p_mode = 2'd0; p_lv = '0;
    {b_en, b_clear, b_load, b_win} = '0; b_mode = 2'd0; b_lv = '0;
    {s_en, s_clear, s_load, s_win} = '0; s_mode = 2'd0; s_lv = '0;
    step(2);
    chk("rst_count", 32'(a_count), 32'h0);
    chk("rst_led",   32'(a_led),   32'h0);
    chk("rst_wrap",  32'(a_wrap),  32'h0);
    rst_n = 1'b1;

    // Up-count 5 cycles, then freeze and see the LED catch up
    a_mode = 2'd0; a_en = 1'b1;
    step(5);
    chk("up5_count", 32'(a_count), 32'd5);
    chk("up5_wrap",  32'(a_wrap),  32'd0);
    chk("up5_led_lag", 32'(a_led), 32'd4);
    a_en = 1'b0;
    step(1);
    chk("freeze_count", 32'(a_count), 32'd5);
    chk("led_follow",   32'(a_led),   32'd5);

    // Wrap from FFFE
    a_lv = 16'hFFFE; a_load = 1'b1;
    step(1);
    chk("load_fffe", 32'(a_count), 32'hFFFE);
    a_load = 1'b0; a_en = 1'b1;
    step(1);
    chk("to_ffff",      32'(a_count), 32'hFFFF);
    chk("to_ffff_wrap", 32'(a_wrap),  32'd0);
    step(1);
    chk("to_0000",      32'(a_count), 32'h0000);
    chk("to_0000_wrap", 32'(a_wrap),  32'd1);
    step(1);
    chk("to_0001_wrap", 32'(a_wrap),  32'd0);

    // HOLD keeps count, no wrap
    a_mode = 2'd3;
    step(2);
    chk("hold_count", 32'(a_count), 32'd1);
    chk("hold_wrap",  32'(a_wrap),  32'd0);
    a_mode = 2'd0;

    // clear beats load beats tick
    a_lv = 16'h1234; a_load = 1'b1; a_clear = 1'b1;
    step(1);
    chk("clear_wins", 32'(a_count), 32'd0);
    a_clear = 1'b0; a_lv = 16'h12AB;
    step(1);
    chk("load_wins", 32'(a_count), 32'h12AB);
    chk("load_nowrap", 32'(a_wrap), 32'd0);
    a_load = 1'b0; a_en = 1'b0; a_win = 1'b1;
    step(1);
    chk("win1_led", 32'(a_led), 32'h12);
    a_win = 1'b0;
    step(1);
    chk("win0_led", 32'(a_led), 32'hAB);

    // Prescale 4, DOWN from 3, with a 3-cycle enable gap
    p_lv = 16'd3; p_load = 1'b1;
    step(1);
    p_load = 1'b0; p_mode = 2'd1; p_en = 1'b1;
    step(3);
    chk("ps_no_tick", 32'(p_count), 32'd3);
    step(1);
    chk("ps_tick1", 32'(p_count), 32'd2);
    step(4);
    chk("ps_tick2", 32'(p_count), 32'd1);
    step(2);
    p_en = 1'b0;
    step(3);
    chk("ps_paused", 32'(p_count), 32'd1);
    p_en = 1'b1;
    step(1);
    chk("ps_resume", 32'(p_count), 32'd1);
    step(1);
    chk("ps_tick3", 32'(p_count), 32'd0);
    chk("ps_tick3_wrap", 32'(p_wrap), 32'd0);
    step(3);
    chk("ps_hold0", 32'(p_count), 32'd0);
    step(1);
    chk("ps_tick4", 32'(p_count), 32'hFFFF);
    chk("ps_tick4_wrap", 32'(p_wrap), 32'd1);
    step(1);
    chk("ps_wrap_pulse", 32'(p_wrap), 32'd0);

    // Bounce, N=4, out-of-range window selects window 0
    b_lv = 4'd14; b_load = 1'b1; b_win = 1'b1;
    step(1);
    b_load = 1'b0; b_mode = 2'd2; b_en = 1'b1;
    step(1);
    chk("bn_15", 32'(b_count), 32'd15);
    chk("bn_15_wrap", 32'(b_wrap), 32'd1);
    step(1);
    chk("bn_14", 32'(b_count), 32'd14);
    chk("bn_14_wrap", 32'(b_wrap), 32'd0);
    step(1);
    chk("bn_13", 32'(b_count), 32'd13);
    step(12);
    chk("bn_1", 32'(b_count), 32'd1);
    step(1);
    chk("bn_0", 32'(b_count), 32'd0);
    chk("bn_0_wrap", 32'(b_wrap), 32'd1);
    step(1);
    chk("bn_1b", 32'(b_count), 32'd1);
    chk("bn_1b_wrap", 32'(b_wrap), 32'd0);
    chk("bn_led_win0", 32'(b_led), 32'd0);

    // Saturating up from FFFD
    s_lv = 16'hFFFD; s_load = 1'b1;
    step(1);
    s_load = 1'b0; s_en = 1'b1;
    step(1);
    chk("sat_fffe", 32'(s_count), 32'hFFFE);
    chk("sat_fffe_wrap", 32'(s_wrap), 32'd0);
    step(1);
    chk("sat_ffff", 32'(s_count), 32'hFFFF);
    chk("sat_ffff_wrap", 32'(s_wrap), 32'd1);
    step(1);
    chk("sat_held", 32'(s_count), 32'hFFFF);
    chk("sat_held_wrap", 32'(s_wrap), 32'd0);

    // Async reset mid-cycle
    a_en = 1'b1;
    step(3);
    chk("pre_rst_count", 32'(a_count), 32'h12AE);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(a_count), 32'd0);
    chk("async_rst_led",   32'(a_led),   32'd0);
    chk("async_rst_s",     32'(s_count), 32'd0);
    step(1);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnt_window.md
# cnt_window

Parametrised free-running/loadable counter with prescaler, count modes (up, down, bounce, hold), wrap/saturate policy and a selectable LED display window. Generalisation of the fixed 16-bit enable counter that drives the board LEDs: any width, any prescale ratio, runtime direction, and runtime choice of which counter byte is shown. Sits between the PLL-derived clock domain and the LED pins; single clock domain.

## Interface
- N, 16, counter width; must be a multiple of LED_W
- LED_W, 8, LED bus width
- PRESCALE, 1, enabled cycles per count tick (1 = every cycle); ≥1
- SATURATE, 0, 1 = stop at limit instead of wrapping (UP/DOWN modes only)
- clk  in  1  counter clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  counting enabled; 0 freezes counter and prescaler
- mode  in  2  count_mode_t: UP=0, DOWN=1, BOUNCE=2, HOLD=3
- clear  in  1  synchronous clear of counter, prescaler, bounce direction
- load  in  1  synchronous load of load_val
- load_val  in  N  value to load
- win_sel  in  WS_W = max(1, clog2(N/LED_W))  LED window select
- count  out  N  current counter value
- led_bus  out  LED_W  registered window count[win_sel*LED_W +: LED_W]
- wrap  out  1  one-cycle pulse on wrap, saturation hit, or bounce reversal

## Operation
- Priority per cycle: clear > load > tick > hold. clear/load act regardless of enable.
- clear: count←0, prescaler←0, dir←up, wrap←0.
- load: count←load_val, prescaler←0, dir unchanged, wrap←0.
- Prescaler: increments when enable=1; at PRESCALE-1 emits tick and returns to 0. PRESCALE=1: tick every enabled cycle.
- On tick:
  - UP: count+1; at 2^N-1 → 0 and wrap=1 (SATURATE=1: stays 2^N-1, wrap=1 only on the tick that reaches 2^N-1).
  - DOWN: count-1; at 0 → 2^N-1 and wrap=1 (SATURATE=1: stays 0, wrap=1 only on the tick that reaches 0).
  - BOUNCE: moves in dir; upon reaching 2^N-1 dir←down, upon reaching 0 dir←up; wrap=1 on the tick that reaches the endpoint. SATURATE ignored.
  - HOLD: count unchanged, wrap=0; prescaler keeps running.
- Mode change takes effect on the next tick; dir retained when leaving and re-entering BOUNCE.
- win_sel ≥ N/LED_W: led_bus shows window 0.
- All arithmetic modulo 2^N; no sign.

## Timing
- Reset (rst=0, async): count=0, led_bus=0, wrap=0, prescaler=0, dir=up. Deassertion synchronised by caller; block samples on first clk edge after release.
- count updates on the clk edge where tick is high; wrap is registered with count (same edge), high exactly one cycle.
- led_bus lags count and win_sel by one cycle.
- First tick after clear/load/enable-rise occurs PRESCALE enabled cycles later.
- enable low mid-prescale: prescaler value held, resumes on enable high.
- load and tick same cycle: load wins, no tick applied, no wrap.
- rst asserted mid-count: all state returns to reset values immediately.

## Structure
- Package cnt_pkg: count_mode_t enum (2-bit), dir_t (UP_DIR/DOWN_DIR).
- Sub-module tick_gen (PRESCALE param; clk, rst, enable, clear → tick): the prescaler; clear input driven by clear|load.
- Top: mode/dir next-state logic, count register, wrap register, LED window mux + output register.

## Test plan
- Reset then N=16, PRESCALE=1, UP, enable=1 for 5 cycles → count=5, led_bus (win_sel=0)=5 one cycle later, wrap=0.
- load_val=16'hFFFE, UP, SATURATE=0 → count FFFF then 0000, wrap=1 on the 0000 edge only.
- PRESCALE=4, DOWN from load 3 → count changes every 4th cycle: 2,1,0,FFFF; enable dropped for 3 cycles mid-way delays next tick by exactly 3.
- BOUNCE, N=4, LED_W=4, load 14 → 15,14,13 with wrap on reaching 15; later 1,0,1 with wrap on reaching 0.
- SATURATE=1, UP from FFFD → FFFE, FFFF(wrap=1), FFFF(wrap=0) held.
- load and clear asserted together with tick → count=0; load alone with tick → count=load_val; win_sel=1 with count=16'h12AB → led_bus=8'h12; rst pulsed mid-run → count=0, led_bus=0 immediately.
